// File: rtl/bsas5b_pkg.sv
// Shared definitions for the BSAS5B arbiter: operand width, default
// timeout and FSM state encodings.
package bsas5b_pkg;

  localparam int W               = 5;
  localparam int TIMEOUT_DEFAULT = 31;

  // state  | meaning
  // IDLE   | waiting for a request; grant and latch operands
  // LOAD   | operands on bsas_x/bsas_y, N low
  // START  | N high, waiting for done (or timeout)
  // DRAIN  | N low, waiting for done to fall (or timeout)
  // RESP   | one-cycle ack to the granted requester
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

endpackage

// File: rtl/bsas5b_rr_arb2.sv
// Two-way round-robin grant.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_i[1:0]     : requests
//   update_i       : strobe, records the current grant as "last served"
//   gnt_o[1:0]     : one-hot grant (combinational)
module bsas5b_rr_arb2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  // 1 when requester 1 was served last; reset value makes requester 0 win
  // the first contention.
  logic last1_q;

  always_comb begin
    gnt_o = req_i;
    if (&req_i) gnt_o = last1_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last1_q <= 1'b1;
    end else if (update_i && |gnt_o) begin
      last1_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/bsas5b_arbiter.sv
// Arbiter sharing one BSAS5B adder/subtractor between two requesters.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   reqN_i, subN_i        : request and operation select (1 = X-Y)
//   xN_i, yN_i            : operands, stable while request is high
//   ackN_o                : one-cycle completion pulse
//   result_o, result_err_o: shared result, timeout flag (valid with ack)
//   busy_o                : not IDLE
//   n_o, nadd_o           : adder start and subtract select
//   bsas_x_o, bsas_y_o    : adder operands
//   done_i, xout_i        : adder completion and result
module bsas5b_arbiter
  import bsas5b_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         req0_i,
  input  logic         req1_i,
  input  logic         sub0_i,
  input  logic         sub1_i,
  input  logic [W-1:0] x0_i,
  input  logic [W-1:0] y0_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] y1_i,
  output logic         ack0_o,
  output logic         ack1_o,
  output logic [W-1:0] result_o,
  output logic         result_err_o,
  output logic         busy_o,
  output logic         n_o,
  output logic         nadd_o,
  output logic [W-1:0] bsas_x_o,
  output logic [W-1:0] bsas_y_o,
  input  logic         done_i,
  input  logic [W-1:0] xout_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state_q;
  logic [1:0]    gnt_q;
  logic [1:0]    gnt;
  logic          sub_q;
  logic [W-1:0]  x_q, y_q, res_q;
  logic [CW-1:0] cnt_q;
  logic          ack0_q, ack1_q, err_q, busy_q, n_q, nadd_q;
  logic          grant_en;
  logic          timeout;

  assign grant_en = (state_q == S_IDLE) && (req0_i || req1_i);
  // Counter holds cycles already spent; this is the last allowed cycle.
  assign timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  bsas5b_rr_arb2 u_rr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .req_i    ({req1_i, req0_i}),
    .update_i (grant_en),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      sub_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      n_q     <= 1'b0;
      nadd_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_en) begin
            // Operand registers double as the bsas_x/bsas_y drivers, so
            // they are already valid in LOAD.
            gnt_q   <= gnt;
            sub_q   <= gnt[1] ? sub1_i : sub0_i;
            x_q     <= gnt[1] ? x1_i : x0_i;
            y_q     <= gnt[1] ? y1_i : y0_i;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          n_q     <= 1'b1;
          nadd_q  <= sub_q;
          cnt_q   <= '0;
          state_q <= S_START;
        end
        S_START: begin
          if (done_i) begin
            res_q   <= xout_i;
            n_q     <= 1'b0;
            nadd_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            n_q     <= 1'b0;
            nadd_q  <= 1'b0;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (!done_i) begin
            err_q   <= 1'b0;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            state_q <= S_RESP;
          end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          n_q     <= 1'b0;
          nadd_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign result_o     = res_q;
  assign result_err_o = err_q;
  assign busy_o       = busy_q;
  assign n_o          = n_q;
  assign nadd_o       = nadd_q;
  assign bsas_x_o     = x_q;
  assign bsas_y_o     = y_q;

endmodule

// File: tb/tb_bsas5b_arbiter.sv
module tb_bsas5b_arbiter;

  logic       clk = 1'b0;
  logic       reset_i, req0_i, req1_i, sub0_i, sub1_i;
  logic [4:0] x0_i, y0_i, x1_i, y1_i;
  logic       ack0_o, ack1_o, result_err_o, busy_o, n_o, nadd_o;
  logic [4:0] result_o, bsas_x_o, bsas_y_o;
  logic       done_i = 1'b0;
  logic [4:0] xout_i = 5'd0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // adder model controls
  logic nodone     = 1'b0;
  int   extra_hold = 0;
  int   mcnt       = 0;
  int   holdc      = 0;

  always #5 clk = ~clk;

  bsas5b_arbiter #(.TIMEOUT_CYCLES(31)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_i       (req0_i),
    .req1_i       (req1_i),
    .sub0_i       (sub0_i),
    .sub1_i       (sub1_i),
    .x0_i         (x0_i),
    .y0_i         (y0_i),
    .x1_i         (x1_i),
    .y1_i         (y1_i),
    .ack0_o       (ack0_o),
    .ack1_o       (ack1_o),
    .result_o     (result_o),
    .result_err_o (result_err_o),
    .busy_o       (busy_o),
    .n_o          (n_o),
    .nadd_o       (nadd_o),
    .bsas_x_o     (bsas_x_o),
    .bsas_y_o     (bsas_y_o),
    .done_i       (done_i),
    .xout_i       (xout_i)
  );

  // Behavioural BSAS5B_top: done rises 3 cycles after N, holds while N is
  // high plus extra_hold cycles after N falls.
  always @(posedge clk) begin
    #2;
    if (reset_i) begin
      done_i = 1'b0;
      mcnt   = 0;
      holdc  = 0;
    end else if (n_o && !done_i) begin
      if (!nodone) begin
        mcnt++;
        if (mcnt >= 3) begin
          done_i = 1'b1;
          xout_i = nadd_o ? (bsas_x_o - bsas_y_o) : (bsas_x_o + bsas_y_o);
          holdc  = extra_hold;
        end
      end
    end else if (!n_o && done_i) begin
      if (holdc > 0) holdc--;
      else done_i = 1'b0;
    end else if (!n_o) begin
      mcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an ack; who = 0/1, 2 if both, -1 if none.
  task automatic wait_ack(output int who, output int ncyc, output logic nadd_all,
                          output int drain_cnt);
    logic seen_n;
    int   got;
    who = -1; ncyc = 0; nadd_all = 1'b1; drain_cnt = 0; seen_n = 1'b0; got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack0_o || ack1_o) begin
        who = (ack0_o && ack1_o) ? 2 : (ack1_o ? 1 : 0);
        got = 1;
        break;
      end
      if (n_o) begin
        ncyc++;
        seen_n = 1'b1;
        nadd_all = nadd_all & nadd_o;
      end else if (seen_n && busy_o) begin
        drain_cnt++;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  int   who, ncyc, drain;
  logic nall;
  int   exp_order [4] = '{0, 1, 0, 1};
  int   exp_res   [2] = '{3, 6};

  initial begin
    reset_i = 1'b1; req0_i = 0; req1_i = 0; sub0_i = 0; sub1_i = 0;
    x0_i = 0; y0_i = 0; x1_i = 0; y1_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_n", 32'(n_o), 32'd0);
    chk("rst_nadd", 32'(nadd_o), 32'd0);
    chk("rst_ack", 32'({ack1_o, ack0_o}), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_err", 32'(result_err_o), 32'd0);
    chk("rst_bsas_xy", 32'({bsas_x_o, bsas_y_o}), 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    // 7 + 9 from requester 0
    req0_i = 1; x0_i = 5'd7; y0_i = 5'd9; sub0_i = 0;
    @(negedge clk);
    chk("t1_load_busy", 32'(busy_o), 32'd1);
    chk("t1_load_n", 32'(n_o), 32'd0);
    chk("t1_load_x", 32'(bsas_x_o), 32'd7);
    @(negedge clk);
    chk("t1_start_n", 32'(n_o), 32'd1);
    chk("t1_start_y", 32'(bsas_y_o), 32'd9);
    chk("t1_start_nadd", 32'(nadd_o), 32'd0);
    wait_ack(who, ncyc, nall, drain);
    req0_i = 0;
    chk("t1_who", 32'(who), 32'd0);
    chk("t1_result", 32'(result_o), 32'd16);
    chk("t1_err", 32'(result_err_o), 32'd0);
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack0_o), 32'd0);
    chk("t1_idle_busy", 32'(busy_o), 32'd0);

    // 3 - 5 from requester 1
    req1_i = 1; x1_i = 5'd3; y1_i = 5'd5; sub1_i = 1;
    wait_ack(who, ncyc, nall, drain);
    req1_i = 0;
    chk("t2_who", 32'(who), 32'd1);
    chk("t2_nadd_all", 32'(nall), 32'd1);
    chk("t2_start_seen", 32'(ncyc > 0), 32'd1);
    chk("t2_result", 32'(result_o), 32'd30);
    chk("t2_err", 32'(result_err_o), 32'd0);
    @(negedge clk);

    // contention straight after reset: 0,1,0,1
    reset_i = 1; @(negedge clk); @(negedge clk); reset_i = 0;
    req0_i = 1; req1_i = 1;
    x0_i = 5'd1; y0_i = 5'd2; sub0_i = 0;
    x1_i = 5'd10; y1_i = 5'd4; sub1_i = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, ncyc, nall, drain);
      chk($sformatf("t3_order%0d", k), 32'(who), 32'(exp_order[k]));
      if (who == 0 || who == 1)
        chk($sformatf("t3_result%0d", k), 32'(result_o), 32'(exp_res[who]));
      if (who == 0) req0_i = 0;
      if (who == 1) req1_i = 0;
      @(negedge clk);
      if (k == 0) req0_i = 1;
      if (k == 1) req1_i = 1;
    end
    req0_i = 0; req1_i = 0;
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy_o), 32'd0);

    // adder never completes: timeout after 31 START cycles
    nodone = 1'b1;
    req0_i = 1; x0_i = 5'd1; y0_i = 5'd1; sub0_i = 0;
    wait_ack(who, ncyc, nall, drain);
    req0_i = 0;
    chk("t4_who", 32'(who), 32'd0);
    chk("t4_start_cycles", 32'(ncyc), 32'd31);
    chk("t4_err", 32'(result_err_o), 32'd1);
    chk("t4_result", 32'(result_o), 32'd0);
    chk("t4_n", 32'(n_o), 32'd0);
    @(negedge clk);
    chk("t4_idle_busy", 32'(busy_o), 32'd0);
    nodone = 1'b0;

    // reset during START
    req0_i = 1; x0_i = 5'd4; y0_i = 5'd4;
    for (int i = 0; i < 20 && !n_o; i++) @(negedge clk);
    chk("t5_reach_start", 32'(n_o), 32'd1);
    @(negedge clk);
    reset_i = 1; req0_i = 0;
    @(negedge clk);
    chk("t5_rst_n", 32'(n_o), 32'd0);
    chk("t5_rst_busy", 32'(busy_o), 32'd0);
    chk("t5_rst_ack", 32'({ack1_o, ack0_o}), 32'd0);
    reset_i = 0;
    @(negedge clk);
    req0_i = 1; x0_i = 5'd1; y0_i = 5'd1; sub0_i = 0;
    wait_ack(who, ncyc, nall, drain);
    req0_i = 0;
    chk("t5_who", 32'(who), 32'd0);
    chk("t5_result", 32'(result_o), 32'd2);
    @(negedge clk);

    // req and operands dropped after grant; done held 12 extra cycles
    extra_hold = 12;
    req0_i = 1; x0_i = 5'd5; y0_i = 5'd6; sub0_i = 0;
    @(negedge clk);
    req0_i = 0; x0_i = 5'd0; y0_i = 5'd0;
    wait_ack(who, ncyc, nall, drain);
    chk("t6_who", 32'(who), 32'd0);
    chk("t6_result", 32'(result_o), 32'd11);
    chk("t6_drain_cycles", 32'(drain), 32'd13);
    chk("t6_done_low_at_ack", 32'(done_i), 32'd0);
    extra_hold = 0;
    @(negedge clk);
    chk("t6_ack_pulse", 32'(ack0_o), 32'd0);
    @(negedge clk);
    chk("t6_no_new_op", 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
